// File: rtl/butterfly_unit.sv
// Pipelined Kyber butterfly: Cooley-Tukey (Sel=0) or Gentleman-Sande (Sel=1)
// with one shared multiplier and Barrett reduction, fixed 5-cycle latency.
module butterfly_unit #(
    parameter int Q = 3329
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] a,
    input  logic [11:0] b,
    input  logic [11:0] twf,
    input  logic        Sel,
    output logic [11:0] o_up,
    output logic [11:0] o_dn
);

    // Barrett constants: a 2*log2(Q) shift keeps the quotient error at most 1
    // for any 24-bit product, so one conditional subtract fully reduces.
    localparam int          K   = 2 * $clog2(Q);
    localparam int          M   = (1 << K) / Q;
    localparam logic [12:0] Q13 = 13'(Q);
    localparam logic [12:0] M13 = 13'(M);

    function automatic logic [11:0] mod_add(input logic [11:0] x, input logic [11:0] y);
        logic [12:0] s;
        s = {1'b0, x} + {1'b0, y};
        return (s >= Q13) ? 12'(s - Q13) : s[11:0];
    endfunction

    function automatic logic [11:0] mod_sub(input logic [11:0] x, input logic [11:0] y);
        logic [12:0] s;
        s = {1'b0, x} + Q13 - {1'b0, y};
        return (s >= Q13) ? 12'(s - Q13) : s[11:0];
    endfunction

    logic [11:0] a0_q, a0_d, b0_q, b0_d, w0_q, w0_d;
    logic        sel0_q, sel0_d;

    logic [11:0] a1_q, a1_d, sum1_q, sum1_d, mop1_q, mop1_d, w1_q, w1_d;
    logic        sel1_q, sel1_d;

    logic [23:0] prod2_q, prod2_d;
    logic [11:0] a2_q, a2_d, sum2_q, sum2_d;
    logic        sel2_q, sel2_d;

    logic [12:0] quot3_q, quot3_d;
    logic [23:0] prod3_q, prod3_d;
    logic [11:0] a3_q, a3_d, sum3_q, sum3_d;
    logic        sel3_q, sel3_d;

    logic [11:0] t4_q, t4_d, a4_q, a4_d, sum4_q, sum4_d;
    logic        sel4_q, sel4_d;

    logic [11:0] up_q, up_d, dn_q, dn_d;
    logic [12:0] rem;

    always_comb begin
        a0_d   = a;
        b0_d   = b;
        w0_d   = twf;
        sel0_d = Sel;

        // Mode mux sits in front of the shared multiplier.
        a1_d   = a0_q;
        w1_d   = w0_q;
        sel1_d = sel0_q;
        sum1_d = mod_add(a0_q, b0_q);
        mop1_d = sel0_q ? mod_sub(a0_q, b0_q) : b0_q;

        prod2_d = 24'(mop1_q) * 24'(w1_q);
        a2_d    = a1_q;
        sum2_d  = sum1_q;
        sel2_d  = sel1_q;

        quot3_d = 13'((37'(prod2_q) * 37'(M13)) >> K);
        prod3_d = prod2_q;
        a3_d    = a2_q;
        sum3_d  = sum2_q;
        sel3_d  = sel2_q;

        // The true remainder is below 2Q, so its low 13 bits are exact.
        rem    = 13'(26'(prod3_q) - 26'(quot3_q) * 26'(Q));
        t4_d   = (rem >= Q13) ? 12'(rem - Q13) : rem[11:0];
        a4_d   = a3_q;
        sum4_d = sum3_q;
        sel4_d = sel3_q;

        if (sel4_q) begin
            up_d = t4_q;
            dn_d = sum4_q;
        end else begin
            up_d = mod_add(a4_q, t4_q);
            dn_d = mod_sub(a4_q, t4_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a0_q    <= '0;
            b0_q    <= '0;
            w0_q    <= '0;
            sel0_q  <= 1'b0;
            a1_q    <= '0;
            sum1_q  <= '0;
            mop1_q  <= '0;
            w1_q    <= '0;
            sel1_q  <= 1'b0;
            prod2_q <= '0;
            a2_q    <= '0;
            sum2_q  <= '0;
            sel2_q  <= 1'b0;
            quot3_q <= '0;
            prod3_q <= '0;
            a3_q    <= '0;
            sum3_q  <= '0;
            sel3_q  <= 1'b0;
            t4_q    <= '0;
            a4_q    <= '0;
            sum4_q  <= '0;
            sel4_q  <= 1'b0;
            up_q    <= '0;
            dn_q    <= '0;
        end else begin
            a0_q    <= a0_d;
            b0_q    <= b0_d;
            w0_q    <= w0_d;
            sel0_q  <= sel0_d;
            a1_q    <= a1_d;
            sum1_q  <= sum1_d;
            mop1_q  <= mop1_d;
            w1_q    <= w1_d;
            sel1_q  <= sel1_d;
            prod2_q <= prod2_d;
            a2_q    <= a2_d;
            sum2_q  <= sum2_d;
            sel2_q  <= sel2_d;
            quot3_q <= quot3_d;
            prod3_q <= prod3_d;
            a3_q    <= a3_d;
            sum3_q  <= sum3_d;
            sel3_q  <= sel3_d;
            t4_q    <= t4_d;
            a4_q    <= a4_d;
            sum4_q  <= sum4_d;
            sel4_q  <= sel4_d;
            up_q    <= up_d;
            dn_q    <= dn_d;
        end
    end

    assign o_up = up_q;
    assign o_dn = dn_q;

endmodule

// File: tb/tb_butterfly_unit.sv
// Self-checking bench for butterfly_unit: directed vector table, mid-stream
// reset sequence, and a cycle-by-cycle check of every output against a model.
module tb_butterfly_unit;

    localparam int Q = 3329;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] a, b, twf;
    logic        sel;
    logic [11:0] o_up, o_dn;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic rst;
        int   a, b, twf, sel;
    } hist_t;

    typedef struct {
        int a, b, twf, sel, up, dn;
    } vec_t;

    hist_t hist[$];
    vec_t  vecs[8];

    always #5 clk = ~clk;

    butterfly_unit #(.Q(Q)) dut (
        .clk  (clk),
        .rst  (rst),
        .a    (a),
        .b    (b),
        .twf  (twf),
        .Sel  (sel),
        .o_up (o_up),
        .o_dn (o_dn)
    );

    function automatic void model(input int va, input int vb, input int vw, input int vs,
                                  output int up, output int dn);
        int t, d;
        if (vs == 0) begin
            t  = (vb * vw) % Q;
            up = (va + t) % Q;
            dn = (va + Q - t) % Q;
        end else begin
            d  = (va - vb + Q) % Q;
            up = (d * vw) % Q;
            dn = (va + vb) % Q;
        end
    endfunction

    task automatic compare(input string name, input int got_up, input int got_dn,
                           input int exp_up, input int exp_dn);
        n_checks++;
        if (got_up != exp_up || got_dn != exp_dn) begin
            n_errors++;
            $display("[TB] FAIL %s: got up=%0d dn=%0d, expected up=%0d dn=%0d",
                     name, got_up, got_dn, exp_up, exp_dn);
        end
    endtask

    task automatic checkPair(input string name, input int exp_up, input int exp_dn);
        compare(name, int'(o_up), int'(o_dn), exp_up, exp_dn);
    endtask

    // Output after edge n comes from the sample captured at edge n-5, unless
    // reset was seen at any edge in between, in which case it must be zero.
    task automatic checkOutput();
        int  n, lo, eu, ed;
        bit  any_rst;
        n       = hist.size() - 1;
        lo      = (n >= 5) ? n - 5 : 0;
        any_rst = 1'b0;
        for (int j = lo; j <= n; j++)
            if (hist[j].rst) any_rst = 1'b1;
        if (any_rst) begin
            eu = 0;
            ed = 0;
        end else if (n < 5) begin
            return;
        end else begin
            model(hist[n-5].a, hist[n-5].b, hist[n-5].twf, hist[n-5].sel, eu, ed);
        end
        compare($sformatf("stream@edge%0d", n), int'(o_up), int'(o_dn), eu, ed);
    endtask

    task automatic applyStimulus(input int va, input int vb, input int vw, input int vs);
        @(posedge clk);
        #1;
        a   = 12'(va);
        b   = 12'(vb);
        twf = 12'(vw);
        sel = vs[0];
    endtask

    always @(posedge clk) begin : record
        hist_t h;
        h.rst = rst;
        h.a   = int'(a);
        h.b   = int'(b);
        h.twf = int'(twf);
        h.sel = int'(sel);
        hist.push_back(h);
    end

    always @(negedge clk) begin
        if (hist.size() > 0) checkOutput();
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs[0] = '{1,    2,    3,    0, 7,    3324};
        vecs[1] = '{9,    2,    1,    0, 11,   7};
        vecs[2] = '{0,    9,    1,    1, 3320, 9};
        vecs[3] = '{9,    8,    2,    1, 2,    17};
        vecs[4] = '{3328, 3328, 3328, 0, 0,    3327};
        vecs[5] = '{3328, 3328, 3328, 1, 0,    3327};
        vecs[6] = '{0,    0,    0,    0, 0,    0};
        vecs[7] = '{0,    0,    0,    1, 0,    0};

        rst = 1'b1;
        a   = 12'd100;
        b   = 12'd200;
        twf = 12'd300;
        sel = 1'b1;

        @(posedge clk);
        #2 checkPair("reset_first_edge", 0, 0);
        repeat (4) @(posedge clk);
        #2 checkPair("reset_hold", 0, 0);

        @(posedge clk);
        #1;
        rst = 1'b0;
        a   = '0;
        b   = '0;
        twf = '0;
        sel = 1'b0;
        repeat (7) @(posedge clk);
        #2 checkPair("zero_after_reset", 0, 0);

        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i].a, vecs[i].b, vecs[i].twf, vecs[i].sel);
            @(posedge clk);
            repeat (5) @(posedge clk);
            #2 checkPair($sformatf("vec%0d", i), vecs[i].up, vecs[i].dn);
        end

        for (int i = 0; i < 30; i++) begin
            int s;
            s = (i < 10) ? 0 : (i < 20) ? 1 : (i % 2);
            applyStimulus($urandom_range(Q - 1, 0), $urandom_range(Q - 1, 0),
                          $urandom_range(Q - 1, 0), s);
        end

        for (int i = 0; i < 3; i++)
            applyStimulus($urandom_range(Q - 1, 1), $urandom_range(Q - 1, 1),
                          $urandom_range(Q - 1, 1), i % 2);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        a   = 12'd1;
        b   = 12'd2;
        twf = 12'd3;
        sel = 1'b0;
        @(posedge clk);
        for (int j = 0; j < 5; j++) begin
            #2 checkPair($sformatf("midreset_flush%0d", j), 0, 0);
            @(posedge clk);
        end
        #2 checkPair("midreset_next", 7, 3324);

        for (int i = 0; i < 10000; i++)
            applyStimulus($urandom_range(Q - 1, 0), $urandom_range(Q - 1, 0),
                          $urandom_range(Q - 1, 0), $urandom_range(1, 0));

        repeat (8) @(posedge clk);
        #2;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
